// File: rtl/button_pkg.sv
// Shared button indices, default timing constants and the per-channel repeat state type.
// The game core imports the BTN_* indices from here.
package button_pkg;

    localparam int BTN_LEFT  = 0;
    localparam int BTN_RIGHT = 1;
    localparam int BTN_UP    = 2;
    localparam int BTN_DOWN  = 3;
    localparam int BTN_PRESS = 4;

    localparam int NUM_BUTTONS_DEFAULT     = 5;
    localparam int DEBOUNCE_CYCLES_DEFAULT = 262144;
    localparam int REPEAT_DELAY_DEFAULT    = 12500000;
    localparam int REPEAT_PERIOD_DEFAULT   = 3125000;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DELAY  = 2'd1,
        REPEAT = 2'd2
    } rpt_state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/button_channel.sv
// One button: two-flop synchronizer, debounce filter, registered press/release pulses
// and a hold-to-repeat FSM. Every output comes straight from a flop or an OR of flops.
module button_channel
    import button_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int REPEAT_DELAY    = REPEAT_DELAY_DEFAULT,
    parameter int REPEAT_PERIOD   = REPEAT_PERIOD_DEFAULT,
    parameter bit REPEAT_EN       = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_in,
    output logic level,
    output logic press_pulse,
    output logic release_pulse,
    output logic event_pulse
);

    localparam int DB_W  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int RPT_W = $clog2(max_int(REPEAT_DELAY, REPEAT_PERIOD) + 1);

    localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [RPT_W-1:0] DLY_LAST = RPT_W'(REPEAT_DELAY - 1);
    localparam logic [RPT_W-1:0] PER_LAST = RPT_W'(REPEAT_PERIOD - 1);

    logic            sync0;
    logic            sync1;
    logic [DB_W-1:0] db_cnt;
    logic            flip;
    logic            rise;
    logic            fall;

    rpt_state_t       state;
    rpt_state_t       state_next;
    logic [RPT_W-1:0] rpt_cnt;
    logic [RPT_W-1:0] rpt_cnt_next;
    logic             rpt_pulse;
    logic             rpt_pulse_next;

    // The level flips on the edge that ends the DEBOUNCE_CYCLES-th disagreeing cycle.
    always_comb begin
        flip = (sync1 != level) && (db_cnt == DB_LAST);
        rise = flip && !level;
        fall = flip && level;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync0         <= 1'b0;
            sync1         <= 1'b0;
            level         <= 1'b0;
            db_cnt        <= '0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
        end else begin
            sync0         <= btn_in;
            sync1         <= sync0;
            press_pulse   <= rise;
            release_pulse <= fall;
            if (sync1 == level) begin
                db_cnt <= '0;
            end else if (flip) begin
                level  <= ~level;
                db_cnt <= '0;
            end else begin
                db_cnt <= db_cnt + 1'b1;
            end
        end
    end

    // A debounced release outranks a repeat boundary landing on the same cycle.
    always_comb begin
        state_next     = state;
        rpt_cnt_next   = rpt_cnt;
        rpt_pulse_next = 1'b0;
        case (state)
            IDLE: begin
                if (rise && REPEAT_EN) begin
                    state_next   = DELAY;
                    rpt_cnt_next = '0;
                end
            end
            DELAY: begin
                if (fall) begin
                    state_next   = IDLE;
                    rpt_cnt_next = '0;
                end else if (rpt_cnt == DLY_LAST) begin
                    state_next     = REPEAT;
                    rpt_cnt_next   = '0;
                    rpt_pulse_next = 1'b1;
                end else begin
                    rpt_cnt_next = rpt_cnt + 1'b1;
                end
            end
            REPEAT: begin
                if (fall) begin
                    state_next   = IDLE;
                    rpt_cnt_next = '0;
                end else if (rpt_cnt == PER_LAST) begin
                    rpt_cnt_next   = '0;
                    rpt_pulse_next = 1'b1;
                end else begin
                    rpt_cnt_next = rpt_cnt + 1'b1;
                end
            end
            default: begin
                state_next   = IDLE;
                rpt_cnt_next = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            rpt_cnt   <= '0;
            rpt_pulse <= 1'b0;
        end else begin
            state     <= state_next;
            rpt_cnt   <= rpt_cnt_next;
            rpt_pulse <= rpt_pulse_next;
        end
    end

    assign event_pulse = press_pulse | rpt_pulse;

endmodule

// File: rtl/button_conditioner.sv
// Conditions the raw ui_in buttons into debounced levels and single-cycle pulses.
// Bit order {press, down, up, right, left}; one independent channel per bit.
module button_conditioner
    import button_pkg::*;
#(
    parameter int                     NUM_BUTTONS     = NUM_BUTTONS_DEFAULT,
    parameter int                     DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int                     REPEAT_DELAY    = REPEAT_DELAY_DEFAULT,
    parameter int                     REPEAT_PERIOD   = REPEAT_PERIOD_DEFAULT,
    parameter logic [NUM_BUTTONS-1:0] REPEAT_MASK     = 5'b01111
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_BUTTONS-1:0] btn_in,
    output logic [NUM_BUTTONS-1:0] btn_level,
    output logic [NUM_BUTTONS-1:0] btn_press,
    output logic [NUM_BUTTONS-1:0] btn_release,
    output logic [NUM_BUTTONS-1:0] btn_event
);

    for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_chan
        button_channel #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .REPEAT_DELAY   (REPEAT_DELAY),
            .REPEAT_PERIOD  (REPEAT_PERIOD),
            .REPEAT_EN      (REPEAT_MASK[i])
        ) u_chan (
            .clk          (clk),
            .rst_n        (rst_n),
            .btn_in       (btn_in[i]),
            .level        (btn_level[i]),
            .press_pulse  (btn_press[i]),
            .release_pulse(btn_release[i]),
            .event_pulse  (btn_event[i])
        );
    end

endmodule

// File: tb/tb_button_conditioner.sv
// Randomized and directed stimulus for button_conditioner, checked cycle by cycle
// against a reference model built from sample-history windows and press timestamps.
module tb_button_conditioner;
    import button_pkg::*;

    localparam int NB = 5;
    localparam int DB = 4;
    localparam int RD = 8;
    localparam int RP = 3;
    localparam logic [NB-1:0] MASK = 5'b01111;
    localparam int W = 4 * NB;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [NB-1:0] btn_in = '0;
    logic [NB-1:0] btn_level;
    logic [NB-1:0] btn_press;
    logic [NB-1:0] btn_release;
    logic [NB-1:0] btn_event;

    always #5 clk = ~clk;

    button_conditioner #(
        .NUM_BUTTONS    (NB),
        .DEBOUNCE_CYCLES(DB),
        .REPEAT_DELAY   (RD),
        .REPEAT_PERIOD  (RP),
        .REPEAT_MASK    (MASK)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .btn_in     (btn_in),
        .btn_level  (btn_level),
        .btn_press  (btn_press),
        .btn_release(btn_release),
        .btn_event  (btn_event)
    );

    // Reference model state: raw samples per edge, model level, edge of last press.
    logic [NB-1:0] hist_q[$];
    logic [W-1:0]  exp_q[$];
    logic [NB-1:0] m_level = '0;
    int            press_edge[NB];
    int            edge_n = 0;
    int            vectors = 0;
    int            miscompares = 0;

    logic [NB-1:0] m_pr, m_rl, m_ev;
    bit            all_diff;
    int            age;

    // The level flips at edge n when the samples taken at edges n-DB-1 .. n-2 all
    // disagree with it (two edges are spent in the synchronizer).
    always @(posedge clk) begin
        edge_n = edge_n + 1;
        m_pr = '0;
        m_rl = '0;
        m_ev = '0;
        if (!rst_n) begin
            hist_q.delete();
            for (int i = 0; i < DB + 2; i++) hist_q.push_back('0);
            m_level = '0;
        end else begin
            hist_q.push_back(btn_in);
            while (hist_q.size() > DB + 3) void'(hist_q.pop_front());
            for (int ch = 0; ch < NB; ch++) begin
                all_diff = 1'b1;
                for (int k = 3; k <= DB + 2; k++) begin
                    if (hist_q[hist_q.size() - k][ch] == m_level[ch]) all_diff = 1'b0;
                end
                if (all_diff) begin
                    m_level[ch] = ~m_level[ch];
                    if (m_level[ch]) begin
                        m_pr[ch] = 1'b1;
                        press_edge[ch] = edge_n;
                    end else begin
                        m_rl[ch] = 1'b1;
                    end
                end
                if (MASK[ch] && m_level[ch] && !m_pr[ch]) begin
                    age = edge_n - press_edge[ch];
                    if (age >= RD && ((age - RD) % RP) == 0) m_ev[ch] = 1'b1;
                end
            end
        end
        m_ev = m_ev | m_pr;
        exp_q.push_back({m_level, m_pr, m_rl, m_ev});
    end

    logic [W-1:0] got_v, exp_v;

    always @(posedge clk) begin
        #1;
        vectors = vectors + 1;
        if (exp_q.size() == 0) begin
            miscompares = miscompares + 1;
            $display("FAIL sb_empty edge=%0d: got no expected entry, required one per edge", edge_n);
        end else begin
            exp_v = exp_q.pop_front();
            got_v = {btn_level, btn_press, btn_release, btn_event};
            if (got_v !== exp_v) begin
                miscompares = miscompares + 1;
                $display("FAIL outputs edge=%0d: got lvl=%b prs=%b rel=%b evt=%b, required lvl=%b prs=%b rel=%b evt=%b",
                         edge_n, got_v[4*NB-1:3*NB], got_v[3*NB-1:2*NB], got_v[2*NB-1:NB], got_v[NB-1:0],
                         exp_v[4*NB-1:3*NB], exp_v[3*NB-1:2*NB], exp_v[2*NB-1:NB], exp_v[NB-1:0]);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic hold_btn(input int idx, input int cycles);
        btn_in[idx] = 1'b1;
        tick(cycles);
        btn_in[idx] = 1'b0;
    endtask

    initial begin
        rst_n  = 1'b0;
        btn_in = '0;
        tick(3);
        rst_n = 1'b1;
        tick(2);

        // Steady press on left, then release.
        hold_btn(BTN_LEFT, 12);
        tick(10);

        // Glitch train on up: never DB cycles stable.
        btn_in[BTN_UP] = 1'b1; tick(3);
        btn_in[BTN_UP] = 1'b0; tick(2);
        btn_in[BTN_UP] = 1'b1; tick(3);
        btn_in[BTN_UP] = 1'b0; tick(10);

        // Long hold with repeats; masked press channel.
        hold_btn(BTN_RIGHT, 30);
        tick(12);
        hold_btn(BTN_PRESS, 30);
        tick(12);

        // Release landing exactly on a repeat boundary (hold = RD + RP).
        hold_btn(BTN_RIGHT, RD + RP);
        tick(12);

        // Two channels on the same edge.
        btn_in[BTN_LEFT] = 1'b1;
        btn_in[BTN_DOWN] = 1'b1;
        tick(15);
        btn_in = '0;
        tick(12);

        // Reset asserted during DELAY while the button stays held.
        btn_in[BTN_LEFT] = 1'b1;
        tick(9);
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(30);
        btn_in = '0;
        tick(12);

        // Random segments with occasional short resets.
        for (int s = 0; s < 300; s++) begin
            btn_in = NB'($urandom_range(0, (1 << NB) - 1));
            if ($urandom_range(0, 39) == 0) begin
                rst_n = 1'b0;
                tick($urandom_range(1, 2));
                rst_n = 1'b1;
            end
            tick($urandom_range(1, 16));
        end
        btn_in = '0;
        tick(15);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/button_conditioner.md
# button_conditioner

Input conditioning stage between the raw `ui_in` button pins and the minesweeper game/VGA core. It handles up to NUM_BUTTONS active-high buttons (left, right, up, down, press). For each one it provides:
- a two-flop synchronizer and a debounce filter;
- single-cycle press and release pulses;
- optional hold-to-repeat events.

The game core consumes only these clean single-cycle pulses instead of doing its own edge detection.

## Interface
Parameters:
- NUM_BUTTONS, 5: channel count. Bit order is {press, down, up, right, left}, matching ui_in[4:0].
- DEBOUNCE_CYCLES, 262144: number of consecutive cycles the synchronized input must differ from the debounced level before the level flips. Must be ≥1.
- REPEAT_DELAY, 12500000: cycles from the press event to the first repeat event. Must be ≥1.
- REPEAT_PERIOD, 3125000: cycles between subsequent repeat events. Must be ≥1.
- REPEAT_MASK, 5'b01111: per-channel auto-repeat enable. The default enables the four directions and disables press.

Ports:
- clk, in, 1: pixel clock.
- rst_n, in, 1: reset, synchronous, active-low; clock clk.
- btn_in, in, NUM_BUTTONS: raw asynchronous buttons, 1 = pressed.
- btn_level, out, NUM_BUTTONS: debounced level.
- btn_press, out, NUM_BUTTONS: 1-cycle pulse on a debounced 0→1 transition.
- btn_release, out, NUM_BUTTONS: 1-cycle pulse on a debounced 1→0 transition.
- btn_event, out, NUM_BUTTONS: btn_press OR the repeat pulse. This is the port the game core steers the cursor from.

## Operation
Channels are fully independent. Each channel works as follows.

- **Synchronizer:** sync0 ← btn_in; sync1 ← sync0.
- **Debounce counter:** width $clog2(DEBOUNCE_CYCLES+1).
  - If sync1 == level, the counter clears to 0.
  - Otherwise the counter increments.
  - When sync1 ≠ level and the counter == DEBOUNCE_CYCLES-1, the level inverts and the counter clears.
  - Any glitch shorter than DEBOUNCE_CYCLES cycles is invisible.
- **Pulses:** btn_press / btn_release are registered and asserted in the same cycle btn_level changes. The default is 0.
- **Repeat FSM:** one per channel, states IDLE, DELAY, REPEAT. Repeat counter width is $clog2(max(REPEAT_DELAY, REPEAT_PERIOD)+1).
  - IDLE: on a debounced press, go to DELAY with the counter at 0.
  - DELAY: the counter increments. At REPEAT_DELAY-1, emit a repeat pulse, clear the counter, and go to REPEAT.
  - REPEAT: the counter increments. At REPEAT_PERIOD-1, emit a repeat pulse and clear the counter.
  - DELAY or REPEAT: a debounced release takes priority and returns to IDLE with no pulse that cycle.
  - When REPEAT_MASK[i] = 0, the FSM stays in IDLE permanently.
- btn_event = btn_press | repeat_pulse. Both pulses are registered, so there is no combinational path from btn_in.

## Timing
- **Reset:** all flops clear, including sync0/1, level, counters and FSM (IDLE). All outputs read 0 from the first edge with rst_n = 0.
- **Button held through reset:** after release of reset it is seen as a new press. btn_press fires DEBOUNCE_CYCLES+2 edges later.
- **Latency:** btn_in stable from edge 0 → btn_level/btn_press/btn_event change after edge DEBOUNCE_CYCLES+2.
- **First repeat:** exactly REPEAT_DELAY cycles after the btn_press pulse. Subsequent repeats are every REPEAT_PERIOD cycles.
- **Pulse width:** every pulse is exactly 1 cycle. btn_press and btn_release are never high together on the same channel.
- **Simultaneous channel events:** handled independently; multiple bits of btn_event may be high in one cycle.
- **Release at the repeat boundary:** if release coincides with a repeat count boundary, the release wins and no repeat pulse is emitted.
- **Reset mid-count:** discards partial debounce and repeat progress.

## Structure
- **Package `button_pkg`:** button index localparams (BTN_LEFT=0, BTN_RIGHT=1, BTN_UP=2, BTN_DOWN=3, BTN_PRESS=4), default timing constants, and the repeat-state enum (IDLE/DELAY/REPEAT). The game core imports the indices from it.
- **Sub-module `button_channel`:** one instance per bit via generate. It holds the synchronizer, debounce, pulse generation and repeat FSM, and takes a 1-bit REPEAT_EN parameter.
- **Top level:** only replication and bus assembly.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4, REPEAT_DELAY=8, REPEAT_PERIOD=3.
1. Reset with btn_in=0 → all outputs 0. Then hold btn_in[0]=1 from edge 0 → btn_level[0] and btn_press[0] rise after edge 6; btn_press is 1 cycle wide.
2. Pulse btn_in[2] high for 3 cycles, low for 2, high for 3 (glitch train) → btn_level[2] stays 0 and no pulses occur.
3. Hold btn_in[1] for 30 cycles → btn_event[1] at press cycle P, then at P+8, P+11, P+14 … . btn_release[1] fires 6 edges after the input drops, and no repeat pulse follows it.
4. Hold btn_in[4] for 30 cycles → exactly one btn_event[4] pulse (repeat masked off); btn_release[4] appears on release.
5. Raise btn_in[0] and btn_in[3] on the same edge → both btn_press bits pulse in the same cycle.
6. Hold btn_in[0] and assert rst_n=0 during the DELAY state for 2 cycles → outputs 0 during reset. After reset, btn_press[0] fires 6 edges later and the first repeat comes 8 cycles after that.
